hls_activity_monitor: RTL and testbench

//  Synthesizable, parametrised per-module activity monitor for HLS block-level handshakes
//  (ap_start/ap_ready/ap_done/ap_continue) across NUM_CH monitored sub-modules of the FFT datapath.

---
 rtl/hls_activity_monitor.sv | 240 ++++++++++++++++++++++++
 tb/tb_hls_activity_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_activity_monitor.sv
// -----------------------------------------------------------------------------
// hls_activity_monitor
//
// Purpose:
//   Per-channel activity monitor for HLS block-level handshakes
//   (ap_start / ap_ready / ap_done / ap_continue). Each channel tracks the
//   invocation state of one monitored sub-module. It accumulates run cycles,
//   hold cycles, the invocation count and latency statistics. Results are read
//   back through a registered channel/field read port.
//
// Optional feature:
//   ACT_MON_LATSTAT_EN
//     Defined: per-channel max_lat / min_lat registers are implemented.
//     Undefined: rd_field 4 and 5 read as 0 with rd_err = 0.
//   last_lat is always present.
//
// Parameters:
//   NUM_CH  number of monitored channels (1..32)
//   CNT_W   width of the cycle and latency counters (8..48)
//   INV_W   width of the per-channel invocation counter (4..32)
//
// Ports:
//   clock        single clock; all logic runs on posedge
//   reset_n      asynchronous active-low reset
//   ap_start     per-channel ap_start tap
//   ap_ready     per-channel ap_ready tap (observed only, never used)
//   ap_done      per-channel ap_done tap
//   ap_continue  per-channel ap_continue (tie high where unused)
//   finish       end of run; freezes all statistics
//   clr          synchronous clear of the statistics and of the freeze flag
//   rd_en        read request
//   rd_ch        channel select for the read
//   rd_field     0 run_cyc, 1 hold_cyc, 2 inv_cnt, 3 last_lat,
//                4 max_lat, 5 min_lat, 6 state
//   rd_data      read data, zero-extended, valid one cycle after rd_en
//   rd_valid     rd_data valid
//   rd_err       bad channel or field 7 (rd_data is forced to 0)
//   busy_vec     per-channel state != IDLE
//   frozen       statistics frozen by finish
// -----------------------------------------------------------------------------
module hls_activity_monitor #(
    parameter int  NUM_CH = 5,
    parameter int  CNT_W  = 32,
    parameter int  INV_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_field,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [NUM_CH-1:0] busy_vec,
    output logic              frozen
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_e;

    // ap_ready is a status tap only; this keeps it visibly consumed.
    logic unused_ready;
    assign unused_ready = ^ap_ready;

    state_e             st_q       [NUM_CH];
    state_e             st_d       [NUM_CH];
    logic [CNT_W-1:0]   run_q      [NUM_CH];
    logic [CNT_W-1:0]   run_d      [NUM_CH];
    logic [CNT_W-1:0]   hold_q     [NUM_CH];
    logic [CNT_W-1:0]   hold_d     [NUM_CH];
    logic [CNT_W-1:0]   cur_lat_q  [NUM_CH];
    logic [CNT_W-1:0]   cur_lat_d  [NUM_CH];
    logic [CNT_W-1:0]   last_lat_q [NUM_CH];
    logic [CNT_W-1:0]   last_lat_d [NUM_CH];
    logic [INV_W-1:0]   inv_q      [NUM_CH];
    logic [INV_W-1:0]   inv_d      [NUM_CH];
`ifdef ACT_MON_LATSTAT_EN
    logic [CNT_W-1:0]   max_lat_q  [NUM_CH];
    logic [CNT_W-1:0]   max_lat_d  [NUM_CH];
    logic [CNT_W-1:0]   min_lat_q  [NUM_CH];
    logic [CNT_W-1:0]   min_lat_d  [NUM_CH];
`endif
    logic               frozen_q, frozen_d;
    logic [NUM_CH-1:0]  busy_q;
    logic [CNT_W-1:0]   rd_data_q;
    logic               rd_valid_q, rd_err_q;

    // Saturating increments: the counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [INV_W-1:0] sat_inv(input logic [INV_W-1:0] v);
        return (&v) ? v : v + INV_W'(1);
    endfunction

    always_comb begin
        logic             start_idle;
        logic             active;
        logic             ret_idle;
        logic             upd;
        logic [CNT_W-1:0] lat_now;
        // clr takes priority over finish.
        frozen_d = clr ? 1'b0 : (finish ? 1'b1 : frozen_q);
        upd      = !frozen_q && !clr;
        for (int c = 0; c < NUM_CH; c++) begin
            st_d[c]       = st_q[c];
            run_d[c]      = run_q[c];
            hold_d[c]     = hold_q[c];
            cur_lat_d[c]  = cur_lat_q[c];
            last_lat_d[c] = last_lat_q[c];
            inv_d[c]      = inv_q[c];
`ifdef ACT_MON_LATSTAT_EN
            max_lat_d[c]  = max_lat_q[c];
            min_lat_d[c]  = min_lat_q[c];
`endif
            // A start accepted in IDLE counts as the first run/latency cycle.
            start_idle = (st_q[c] == IDLE) && ap_start[c];
            active     = start_idle || (st_q[c] == RUN);
            lat_now    = start_idle ? CNT_W'(1) : sat_cnt(cur_lat_q[c]);
            ret_idle   = (active && ap_done[c] && ap_continue[c]) ||
                         ((st_q[c] == HOLD) && ap_continue[c]);

            // State tracking and the in-flight latency keep running while frozen.
            if (active) begin
                st_d[c]      = ap_done[c] ? (ap_continue[c] ? IDLE : HOLD) : RUN;
                cur_lat_d[c] = ap_done[c] ? '0 : lat_now;
            end else if ((st_q[c] == HOLD) && ap_continue[c]) begin
                st_d[c] = IDLE;
            end

            if (clr) begin
                run_d[c]      = '0;
                hold_d[c]     = '0;
                last_lat_d[c] = '0;
                inv_d[c]      = '0;
`ifdef ACT_MON_LATSTAT_EN
                max_lat_d[c]  = '0;
                min_lat_d[c]  = '1;
`endif
            end else if (upd) begin
                if (active)
                    run_d[c] = sat_cnt(run_q[c]);
                if (st_q[c] == HOLD)
                    hold_d[c] = sat_cnt(hold_q[c]);
                if (active && ap_done[c]) begin
                    last_lat_d[c] = lat_now;
`ifdef ACT_MON_LATSTAT_EN
                    if (lat_now > max_lat_q[c]) max_lat_d[c] = lat_now;
                    if (lat_now < min_lat_q[c]) min_lat_d[c] = lat_now;
`endif
                end
                if (ret_idle)
                    inv_d[c] = sat_inv(inv_q[c]);
            end
        end
    end

    // Read mux sources the current registers, so rd_data is the pre-edge snapshot.
    logic             rd_bad;
    logic [CH_W-1:0]  ch_idx;
    logic [CNT_W-1:0] rd_val;

    always_comb begin
        rd_bad = (32'(rd_ch) >= NUM_CH) || (rd_field == 3'd7);
        ch_idx = rd_bad ? '0 : rd_ch;
        rd_val = '0;
        case (rd_field)
            3'd0:    rd_val = run_q[ch_idx];
            3'd1:    rd_val = hold_q[ch_idx];
            3'd2:    rd_val = CNT_W'(inv_q[ch_idx]);
            3'd3:    rd_val = last_lat_q[ch_idx];
`ifdef ACT_MON_LATSTAT_EN
            3'd4:    rd_val = max_lat_q[ch_idx];
            3'd5:    rd_val = min_lat_q[ch_idx];
`endif
            3'd6:    rd_val = CNT_W'(st_q[ch_idx]);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]       <= IDLE;
                run_q[c]      <= '0;
                hold_q[c]     <= '0;
                cur_lat_q[c]  <= '0;
                last_lat_q[c] <= '0;
                inv_q[c]      <= '0;
`ifdef ACT_MON_LATSTAT_EN
                max_lat_q[c]  <= '0;
                min_lat_q[c]  <= '1;
`endif
            end
            frozen_q   <= 1'b0;
            busy_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]       <= st_d[c];
                run_q[c]      <= run_d[c];
                hold_q[c]     <= hold_d[c];
                cur_lat_q[c]  <= cur_lat_d[c];
                last_lat_q[c] <= last_lat_d[c];
                inv_q[c]      <= inv_d[c];
`ifdef ACT_MON_LATSTAT_EN
                max_lat_q[c]  <= max_lat_d[c];
                min_lat_q[c]  <= min_lat_d[c];
`endif
                busy_q[c]     <= (st_d[c] != IDLE);
            end
            frozen_q <= frozen_d;
            // rd_data holds its last value when no read is requested.
            if (rd_en) begin
                rd_valid_q <= 1'b1;
                rd_err_q   <= rd_bad;
                rd_data_q  <= rd_bad ? '0 : rd_val;
            end else begin
                rd_valid_q <= 1'b0;
                rd_err_q   <= 1'b0;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign busy_vec = busy_q;
    assign frozen   = frozen_q;

endmodule

// File: tb/tb_hls_activity_monitor.sv
module tb_hls_activity_monitor;
    localparam int     NCH  = 5;
    localparam int     CW   = 8;
    localparam int     IW   = 6;
    localparam longint CMAX = 255;
    localparam longint IMAX = 63;
`ifdef ACT_MON_LATSTAT_EN
    localparam bit LS = 1'b1;
`else
    localparam bit LS = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [NCH-1:0] ap_start = '0, ap_ready = '0, ap_done = '0, ap_continue = '1;
    logic           finish = 1'b0, clr = 1'b0, rd_en = 1'b0;
    logic [2:0]     rd_ch = '0, rd_field = '0;
    logic [CW-1:0]  rd_data;
    logic           rd_valid, rd_err, frozen;
    logic [NCH-1:0] busy_vec;

    always #5 clock = ~clock;

    hls_activity_monitor #(.NUM_CH(NCH), .CNT_W(CW), .INV_W(IW)) dut (
        .clock(clock), .reset_n(reset_n), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clr(clr),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_field(rd_field), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_err(rd_err), .busy_vec(busy_vec), .frozen(frozen)
    );

    int n_chk = 0, n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each channel is idle / in an invocation / holding.
    // Latency is measured from the cycle number at which the invocation started.
    int     mst     [NCH];
    longint run_m   [NCH], hold_m [NCH], inv_m [NCH], last_m [NCH];
    longint mx_m    [NCH], mn_m   [NCH], st_cyc [NCH];
    bit     frz_m, ev_valid, ev_err;
    longint ev_data, cyc = 0;

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    function automatic longint field_m(input int c, input int f);
        case (f)
            0: return run_m[c];
            1: return hold_m[c];
            2: return inv_m[c];
            3: return last_m[c];
            4: return LS ? mx_m[c] : 0;
            5: return LS ? mn_m[c] : 0;
            6: return mst[c];
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mst[c] = 0; run_m[c] = 0; hold_m[c] = 0; inv_m[c] = 0;
            last_m[c] = 0; mx_m[c] = 0; mn_m[c] = CMAX; st_cyc[c] = 0;
        end
        frz_m = 0; ev_valid = 0; ev_err = 0; ev_data = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                if (rd_en) begin
                    ev_valid = 1;
                    ev_err   = (rd_ch >= NCH) || (rd_field == 7);
                    ev_data  = ev_err ? 0 : field_m(int'(rd_ch), int'(rd_field));
                end else begin
                    ev_valid = 0;
                    ev_err   = 0;
                end
                for (int c = 0; c < NCH; c++) begin
                    bit     live, back, upd;
                    longint lat;
                    upd  = !frz_m && !clr;
                    live = (mst[c] == 0 && ap_start[c]) || mst[c] == 1;
                    if (mst[c] == 0 && ap_start[c]) st_cyc[c] = cyc;
                    lat  = sat(cyc - st_cyc[c] + 1, CMAX);
                    back = (live && ap_done[c] && ap_continue[c]) ||
                           (mst[c] == 2 && ap_continue[c]);
                    if (clr) begin
                        run_m[c] = 0; hold_m[c] = 0; inv_m[c] = 0; last_m[c] = 0;
                        mx_m[c] = 0; mn_m[c] = CMAX;
                    end else if (upd) begin
                        if (live) run_m[c] = sat(run_m[c] + 1, CMAX);
                        if (mst[c] == 2) hold_m[c] = sat(hold_m[c] + 1, CMAX);
                        if (live && ap_done[c]) begin
                            last_m[c] = lat;
                            if (lat > mx_m[c]) mx_m[c] = lat;
                            if (lat < mn_m[c]) mn_m[c] = lat;
                        end
                        if (back) inv_m[c] = sat(inv_m[c] + 1, IMAX);
                    end
                    if (live) mst[c] = ap_done[c] ? (ap_continue[c] ? 0 : 2) : 1;
                    else if (mst[c] == 2 && ap_continue[c]) mst[c] = 0;
                end
                frz_m = clr ? 0 : (finish ? 1 : frz_m);
                cyc++;
            end
        end
    end

    // Every-cycle compare of all outputs against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (chk_on) begin
                logic [NCH-1:0] eb;
                for (int c = 0; c < NCH; c++) eb[c] = (mst[c] != 0);
                chk("busy_vec", busy_vec, eb);
                chk("frozen", frozen, frz_m);
                chk("rd_valid", rd_valid, ev_valid);
                chk("rd_err", rd_err, ev_err);
                chk("rd_data", rd_data, ev_data);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic rd_check(input int ch, input int f, input longint exp,
                            input bit exp_err, input string nm);
        rd_en = 1; rd_ch = 3'(ch); rd_field = 3'(f);
        tick();
        rd_en = 0;
        chk({nm, " valid"}, rd_valid, 1);
        chk({nm, " err"}, rd_err, exp_err);
        chk(nm, rd_data, exp);
    endtask

    initial begin
        repeat (3) tick();
        chk_on = 1;
        chk("rst busy_vec", busy_vec, 0);
        chk("rst frozen", frozen, 0);
        chk("rst rd_valid", rd_valid, 0);
        reset_n = 1;
        tick();
        rd_check(0, 5, LS ? CMAX : 0, 0, "t1 min_lat");

        // Ch1: start in cycle 0, done with continue in cycle 4.
        ap_start[1] = 1; tick(); ap_start[1] = 0;
        repeat (3) tick();
        ap_done[1] = 1; tick(); ap_done[1] = 0;
        rd_check(1, 0, 5, 0, "t2 run_cyc");
        rd_check(1, 3, 5, 0, "t2 last_lat");
        rd_check(1, 2, 1, 0, "t2 inv_cnt");
        rd_check(1, 1, 0, 0, "t2 hold_cyc");

        // Ch2: done without continue, three hold cycles, then released.
        ap_start[2] = 1; tick(); ap_start[2] = 0;
        tick();
        ap_done[2] = 1; ap_continue[2] = 0; tick(); ap_done[2] = 0;
        repeat (2) tick();
        chk("t3 busy in hold", busy_vec[2], 1);
        ap_continue[2] = 1; tick();
        rd_check(2, 1, 3, 0, "t3 hold_cyc");
        rd_check(2, 2, 1, 0, "t3 inv_cnt");
        rd_check(2, 6, 0, 0, "t3 state");
        rd_check(2, 0, 3, 0, "t3 run_cyc");

        // Ch3: single-cycle invocations twice.
        ap_start[3] = 1; ap_done[3] = 1; tick(); tick();
        ap_start[3] = 0; ap_done[3] = 0;
        rd_check(3, 3, 1, 0, "t4 last_lat");
        rd_check(3, 2, 2, 0, "t4 inv_cnt");
        rd_check(3, 4, LS ? 1 : 0, 0, "t4 max_lat");
        rd_check(3, 5, LS ? 1 : 0, 0, "t4 min_lat");

        // Ch4: freeze mid-invocation, then clear.
        ap_start[4] = 1; tick(); ap_start[4] = 0;
        repeat (2) tick();
        finish = 1; tick(); finish = 0;
        chk("t5 frozen", frozen, 1);
        repeat (3) tick();
        rd_check(4, 0, 4, 0, "t5 run frozen");
        chk("t5 busy live", busy_vec[4], 1);
        ap_done[4] = 1; tick(); ap_done[4] = 0;
        chk("t5 busy after done", busy_vec[4], 0);
        rd_check(4, 2, 0, 0, "t5 inv frozen");
        clr = 1; tick(); clr = 0;
        chk("t5 frozen after clr", frozen, 0);
        rd_check(1, 0, 0, 0, "t5 run cleared");
        rd_check(3, 2, 0, 0, "t5 inv cleared");
        rd_check(3, 5, LS ? CMAX : 0, 0, "t5 min restored");
        finish = 1; tick();
        clr = 1; tick(); clr = 0; finish = 0;
        chk("t5 clr beats finish", frozen, 0);

        // Bad reads.
        rd_check(5, 0, 0, 1, "t6 bad ch");
        rd_check(0, 7, 0, 1, "t6 bad field");

        // Saturation: 300-cycle invocation on ch0.
        ap_start[0] = 1; tick(); ap_start[0] = 0;
        repeat (298) tick();
        ap_done[0] = 1; tick(); ap_done[0] = 0;
        rd_check(0, 0, CMAX, 0, "t6 run sat");
        rd_check(0, 3, CMAX, 0, "t6 last_lat sat");

        // Reset mid-invocation aborts it.
        ap_start[1] = 1; tick(); ap_start[1] = 0; tick();
        reset_n = 0; tick(); reset_n = 1;
        chk("abort busy", busy_vec, 0);
        rd_check(1, 0, 0, 0, "abort run");

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                ap_start[c]    = ($urandom_range(0, 2) == 0);
                ap_done[c]     = ($urandom_range(0, 3) == 0);
                ap_continue[c] = ($urandom_range(0, 3) != 0);
                ap_ready[c]    = $urandom_range(0, 1) == 1;
            end
            finish   = ($urandom_range(0, 299) == 0);
            clr      = ($urandom_range(0, 199) == 0);
            rd_en    = $urandom_range(0, 1) == 1;
            rd_ch    = 3'($urandom_range(0, 7));
            rd_field = 3'($urandom_range(0, 7));
            reset_n  = ($urandom_range(0, 999) != 0);
            tick();
        end
        reset_n = 1; rd_en = 0; finish = 0; clr = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
